// File: rtl/nes_load_pkg.sv
// Shared types and helpers for the NES ROM download streamer.
package nes_load_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EMIT,
    GAP,
    TAIL
  } streamer_state_t;

  localparam int DEFAULT_PACE_CYCLES = 8;
  localparam int DEFAULT_TAIL_CYCLES = 16;

  // File byte order is MSB-first: index 0 selects word[31:24].
  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and registered full/empty flags.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] q,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt, cnt_nxt;
  logic             push_eff, pop_eff;

  always_comb begin
    pop_eff  = pop && !empty;
    push_eff = push && (!full || pop_eff);
    cnt_nxt  = cnt;
    if (push_eff && !pop_eff)      cnt_nxt = cnt + (AW+1)'(1);
    else if (!push_eff && pop_eff) cnt_nxt = cnt - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (pop_eff) begin
      q <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + AW'(1);
      if (pop_eff)  rd_ptr <= rd_ptr + AW'(1);
      cnt   <= cnt_nxt;
      full  <= (cnt_nxt == FULL_CNT);
      empty <= (cnt_nxt == '0);
    end
  end

endmodule

// File: rtl/nes_rom_byte_streamer.sv
// Serialises 32-bit ROM words into paced ioctl byte writes framed by ioctl_download.
module nes_rom_byte_streamer
  import nes_load_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int PACE_CYCLES = DEFAULT_PACE_CYCLES,
  parameter int TAIL_CYCLES = DEFAULT_TAIL_CYCLES,
  parameter int ADDR_W      = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [31:0]       load_len,
  input  logic              word_valid,
  input  logic [31:0]       word_data,
  output logic              word_ready,
  output logic              ioctl_download,
  output logic              ioctl_wr,
  output logic [7:0]        ioctl_dout,
  output logic [ADDR_W-1:0] ioctl_addr,
  output logic              busy,
  output logic              len_err
);

  localparam int PW = $clog2(PACE_CYCLES) + 1;
  localparam int TW = $clog2(TAIL_CYCLES) + 1;
  localparam logic [PW-1:0] PACE_RELOAD = PW'(PACE_CYCLES - 2);
  localparam logic [TW-1:0] TAIL_RELOAD = TW'(TAIL_CYCLES - 2);

  streamer_state_t state_q, state_d;

  logic [31:0]   remaining, len_q, words_acc;
  logic [1:0]    byte_idx;
  logic [PW-1:0] pace_cnt;
  logic [TW-1:0] tail_cnt;

  logic        fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [31:0] fifo_q;
  logic        start_acc, accept, overrun;
  logic        idx_clr, idx_inc, pace_load, pace_dec, tail_load, tail_dec;

  assign busy           = (state_q != IDLE);
  assign ioctl_download = busy;
  assign word_ready     = busy && !fifo_full;
  assign start_acc      = load_start && (state_q == IDLE);
  assign accept         = word_valid && word_ready;
  assign overrun        = ({words_acc, 2'b00} >= {2'b00, len_q});
  assign fifo_push      = accept && !overrun;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (start_acc),
    .push  (fifo_push),
    .din   (word_data),
    .pop   (fifo_pop),
    .q     (fifo_q),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // GAP leaves for TAIL as soon as the last byte is out; TAIL itself lasts
  // TAIL_CYCLES-1, so download falls exactly TAIL_CYCLES after the last strobe.
  always_comb begin
    state_d   = state_q;
    fifo_pop  = 1'b0;
    idx_clr   = 1'b0;
    idx_inc   = 1'b0;
    pace_load = 1'b0;
    pace_dec  = 1'b0;
    tail_load = 1'b0;
    tail_dec  = 1'b0;
    case (state_q)
      IDLE: if (load_start) state_d = LOAD;
      LOAD: begin
        if (remaining == '0) begin
          state_d   = TAIL;
          tail_load = 1'b1;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          idx_clr  = 1'b1;
          state_d  = EMIT;
        end
      end
      EMIT: begin
        state_d   = GAP;
        pace_load = 1'b1;
      end
      GAP: begin
        if (remaining == '0) begin
          state_d   = TAIL;
          tail_load = 1'b1;
        end else if (pace_cnt != '0) begin
          pace_dec = 1'b1;
        end else if (byte_idx != 2'd3) begin
          idx_inc = 1'b1;
          state_d = EMIT;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          idx_clr  = 1'b1;
          state_d  = EMIT;
        end
      end
      TAIL: begin
        if (tail_cnt == '0) state_d = IDLE;
        else                tail_dec = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ioctl_wr   <= 1'b0;
      ioctl_dout <= '0;
      ioctl_addr <= '0;
      len_err    <= 1'b0;
      remaining  <= '0;
      len_q      <= '0;
      words_acc  <= '0;
      byte_idx   <= '0;
      pace_cnt   <= '0;
      tail_cnt   <= '0;
    end else begin
      ioctl_wr <= (state_q == EMIT);
      if (state_q == EMIT) begin
        ioctl_dout <= byte_sel(fifo_q, byte_idx);
        remaining  <= remaining - 32'd1;
      end
      if (ioctl_wr) ioctl_addr <= ioctl_addr + ADDR_W'(1);

      if (idx_clr)      byte_idx <= '0;
      else if (idx_inc) byte_idx <= byte_idx + 2'd1;

      if (pace_load)     pace_cnt <= PACE_RELOAD;
      else if (pace_dec) pace_cnt <= pace_cnt - PW'(1);

      if (tail_load)     tail_cnt <= TAIL_RELOAD;
      else if (tail_dec) tail_cnt <= tail_cnt - TW'(1);

      if (fifo_push)          words_acc <= words_acc + 32'd1;
      if (accept && overrun)  len_err   <= 1'b1;

      if (start_acc) begin
        remaining  <= load_len;
        len_q      <= load_len;
        ioctl_addr <= '0;
        len_err    <= 1'b0;
        words_acc  <= '0;
        byte_idx   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_nes_rom_byte_streamer.sv
// Directed bench for nes_rom_byte_streamer: vector table plus multi-cycle corner sequences.
module tb_nes_rom_byte_streamer;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic [31:0] load_len;
  logic        word_valid;
  logic [31:0] word_data;
  logic        word_ready;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [7:0]  ioctl_dout;
  logic [24:0] ioctl_addr;
  logic        busy;
  logic        len_err;

  nes_rom_byte_streamer #(
    .FIFO_DEPTH  (16),
    .PACE_CYCLES (8),
    .TAIL_CYCLES (16),
    .ADDR_W      (25)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .load_start     (load_start),
    .load_len       (load_len),
    .word_valid     (word_valid),
    .word_data      (word_data),
    .word_ready     (word_ready),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_addr     (ioctl_addr),
    .busy           (busy),
    .len_err        (len_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]       len;
    logic [2:0]        nwords;
    logic [0:3][31:0]  w;
    logic [3:0]        exp_n;
    logic [0:7][7:0]   exp_b;
    logic              exp_err;
  } vec_t;

  vec_t vecs [6];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [7:0]  q_dout [$];
  logic [24:0] q_addr [$];
  int          q_cyc  [$];
  int          rise_cyc, fall_cyc, ready_low_cnt;
  logic        dl_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ioctl_wr) begin
      q_dout.push_back(ioctl_dout);
      q_addr.push_back(ioctl_addr);
      q_cyc.push_back(cyc);
    end
    if (ioctl_download && !dl_prev) rise_cyc = cyc;
    if (!ioctl_download && dl_prev) fall_cyc = cyc;
    if (busy && !word_ready) ready_low_cnt++;
    dl_prev = ioctl_download;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic clear_mon();
    q_dout.delete();
    q_addr.delete();
    q_cyc.delete();
    rise_cyc      = -1;
    fall_cyc      = -1;
    ready_low_cnt = 0;
  endtask

  task automatic pulse_start(input logic [31:0] len);
    @(negedge clk);
    load_start = 1'b1;
    load_len   = len;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w, output int acc_cyc);
    bit done = 0;
    int n = 0;
    acc_cyc = -1;
    while (!done && n < 300) begin
      @(negedge clk);
      word_valid = 1'b1;
      word_data  = w;
      if (word_ready) begin
        @(posedge clk);
        #1;
        acc_cyc    = cyc;
        word_valid = 1'b0;
        done       = 1;
      end
      n++;
    end
    word_valid = 1'b0;
    if (!done) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 32'd1, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_strobes(input int cnt, input int budget);
    int n = 0;
    while (q_dout.size() < cnt && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q_dout.size() < cnt) check("strobe_timeout", 32'(q_dout.size()), 32'(cnt));
  endtask

  // Ramp check: byte i must equal i and sit at address i.
  task automatic check_ramp(input string tag, input int n, input bit spacing);
    check({tag, "_count"}, 32'(q_dout.size()), 32'(n));
    for (int i = 0; i < n && i < q_dout.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), 32'(q_dout[i]), 32'(i & 8'hFF));
      check($sformatf("%s_addr%0d", tag, i), 32'(q_addr[i]), 32'(i));
      if (spacing && i > 0)
        check($sformatf("%s_space%0d", tag, i), 32'(q_cyc[i] - q_cyc[i-1]), 32'd8);
    end
  endtask

  initial begin
    int acc;
    int acc_w2;
    vec_t v;

    vecs[0] = '{len: 32'd8, nwords: 3'd2,
                w: {32'h4E45531A, 32'h01020304, 32'h0, 32'h0}, exp_n: 4'd8,
                exp_b: {8'h4E, 8'h45, 8'h53, 8'h1A, 8'h01, 8'h02, 8'h03, 8'h04}, exp_err: 1'b0};
    vecs[1] = '{len: 32'd6, nwords: 3'd2,
                w: {32'hAABBCCDD, 32'h11223344, 32'h0, 32'h0}, exp_n: 4'd6,
                exp_b: {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h00, 8'h00}, exp_err: 1'b0};
    vecs[2] = '{len: 32'd4, nwords: 3'd3,
                w: {32'hDEADBEEF, 32'h11111111, 32'h22222222, 32'h0}, exp_n: 4'd4,
                exp_b: {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h00}, exp_err: 1'b1};
    vecs[3] = '{len: 32'd0, nwords: 3'd0,
                w: {32'h0, 32'h0, 32'h0, 32'h0}, exp_n: 4'd0,
                exp_b: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, exp_err: 1'b0};
    vecs[4] = '{len: 32'd3, nwords: 3'd1,
                w: {32'hCAFEF00D, 32'h0, 32'h0, 32'h0}, exp_n: 4'd3,
                exp_b: {8'hCA, 8'hFE, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, exp_err: 1'b0};
    vecs[5] = '{len: 32'd5, nwords: 3'd2,
                w: {32'h01234567, 32'h89ABCDEF, 32'h0, 32'h0}, exp_n: 4'd5,
                exp_b: {8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'h00, 8'h00, 8'h00}, exp_err: 1'b0};

    reset      = 1'b1;
    load_start = 1'b0;
    load_len   = '0;
    word_valid = 1'b0;
    word_data  = '0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    check("rst_download", 32'(ioctl_download), 32'd0);
    check("rst_wr",       32'(ioctl_wr),       32'd0);
    check("rst_dout",     32'(ioctl_dout),     32'd0);
    check("rst_addr",     32'(ioctl_addr),     32'd0);
    check("rst_busy",     32'(busy),           32'd0);
    check("rst_len_err",  32'(len_err),        32'd0);
    check("rst_ready",    32'(word_ready),     32'd0);
    reset = 1'b0;

    for (int k = 0; k < 6; k++) begin
      v = vecs[k];
      clear_mon();
      pulse_start(v.len);
      for (int i = 0; i < int'(v.nwords); i++) push_word(v.w[i], acc);
      wait_idle(2000);
      check($sformatf("v%0d_count", k), 32'(q_dout.size()), 32'(v.exp_n));
      for (int i = 0; i < int'(v.exp_n) && i < q_dout.size(); i++) begin
        check($sformatf("v%0d_byte%0d", k, i), 32'(q_dout[i]), 32'(v.exp_b[i]));
        check($sformatf("v%0d_addr%0d", k, i), 32'(q_addr[i]), 32'(i));
        if (i > 0)
          check($sformatf("v%0d_space%0d", k, i), 32'(q_cyc[i] - q_cyc[i-1]), 32'd8);
      end
      if (v.exp_n != 0 && q_cyc.size() != 0) begin
        check($sformatf("v%0d_tail", k), 32'(fall_cyc - q_cyc[q_cyc.size()-1]), 32'd16);
      end else begin
        check($sformatf("v%0d_dl_len", k), 32'(fall_cyc - rise_cyc), 32'd16);
        check($sformatf("v%0d_ready_low", k), 32'(ready_low_cnt), 32'd0);
      end
      check($sformatf("v%0d_len_err", k), 32'(len_err), 32'(v.exp_err));
    end

    // Back-to-back burst larger than the FIFO.
    clear_mon();
    pulse_start(32'd80);
    for (int i = 0; i < 20; i++)
      push_word({8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)}, acc);
    wait_idle(3000);
    check("bp_ready_dropped", 32'(ready_low_cnt != 0), 32'd1);
    check_ramp("bp", 80, 1'b1);
    check("bp_len_err", 32'(len_err), 32'd0);

    // Upstream stall: FIFO drains, then a new word must strobe two edges after acceptance.
    clear_mon();
    pulse_start(32'd40);
    push_word(32'h00010203, acc);
    push_word(32'h04050607, acc);
    repeat (100) @(negedge clk);
    push_word(32'h08090A0B, acc_w2);
    for (int i = 3; i < 10; i++)
      push_word({8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)}, acc);
    wait_idle(3000);
    check_ramp("stall", 40, 1'b0);
    if (q_cyc.size() > 8) begin
      check("stall_latency", 32'(q_cyc[8] - acc_w2), 32'd2);
      check("stall_gap_long", 32'(q_cyc[8] - q_cyc[7] > 8), 32'd1);
      check("stall_after_space", 32'(q_cyc[9] - q_cyc[8]), 32'd8);
    end else begin
      check("stall_short", 32'(q_cyc.size()), 32'd40);
    end

    // Reset mid-transfer after the third strobe.
    clear_mon();
    pulse_start(32'd8);
    push_word(32'h4E45531A, acc);
    push_word(32'h01020304, acc);
    wait_strobes(3, 500);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_download", 32'(ioctl_download), 32'd0);
    check("abort_wr",       32'(ioctl_wr),       32'd0);
    check("abort_addr",     32'(ioctl_addr),     32'd0);
    check("abort_busy",     32'(busy),           32'd0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_no_more_wr", 32'(q_dout.size()), 32'd3);
    clear_mon();
    pulse_start(32'd4);
    push_word(32'h00010203, acc);
    wait_idle(500);
    check_ramp("restart", 4, 1'b1);

    // load_start while busy is ignored and does not touch len_err.
    clear_mon();
    pulse_start(32'd4);
    push_word(32'h0A0B0C0D, acc);
    push_word(32'h0E0F1011, acc);
    wait_strobes(2, 500);
    pulse_start(32'd100);
    wait_idle(1000);
    check("ign_count", 32'(q_dout.size()), 32'd4);
    if (q_dout.size() >= 4) begin
      check("ign_byte3", 32'(q_dout[3]), 32'h0D);
      check("ign_addr3", 32'(q_addr[3]), 32'd3);
    end
    check("ign_len_err", 32'(len_err), 32'd1);
    clear_mon();
    pulse_start(32'd0);
    check("start_clears_len_err", 32'(len_err), 32'd0);
    wait_idle(500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
